dctq_zigzag_buffer: RTL

DCTQ_ZIGZAG_BUFFER -- requirements
Module: dctq_zigzag_buffer

---
 rtl/dctq_pkg.sv | 29 ++
 rtl/dctq_zigzag_rom.sv | 12 +
 rtl/dctq_zigzag_buffer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dctq_pkg.sv
// Shared definitions for the quantizer-to-entropy-coder zigzag reorder buffer:
// default coefficient width, zigzag-to-raster map and read FSM encoding.
package dctq_pkg;

   localparam int COEFF_W_DEF = 12;
   localparam int BLK_N       = 64;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_t;

   // Element [k] is the raster address of zigzag position k (left index is MSB).
   localparam logic [0:BLK_N-1][5:0] ZZ_TABLE = {
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   function automatic logic [5:0] zz_to_raster(input logic [5:0] zz_idx);
      return ZZ_TABLE[zz_idx];
   endfunction

endpackage

// File: rtl/dctq_zigzag_rom.sv
// Zigzag position to raster address lookup; purely combinational, no latency,
// no flow control.
module dctq_zigzag_rom
   import dctq_pkg::*;
(
   input  logic [5:0] i_zz_idx,
   output logic [5:0] o_raster_addr
);

   assign o_raster_addr = zz_to_raster(i_zz_idx);

endmodule

// File: rtl/dctq_zigzag_buffer.sv
// Ping-pong 8x8 block buffer: raster-order writes in, zigzag-order stream out; first
// coefficient 1 cycle after STREAM entry. Writes into a full bank drop (sticky overflow); out_ready stalls only the read side.
module dctq_zigzag_buffer
   import dctq_pkg::*;
#(
   parameter int COEFF_W = COEFF_W_DEF
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      hold,
   input  logic                      dctq_valid,
   input  logic [5:0]                addr,
   input  logic signed [COEFF_W-1:0] qcoeff,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic signed [COEFF_W-1:0] out_coeff,
   output logic [5:0]                out_index,
   output logic                      blk_last,
   output logic                      buf_full,
   output logic                      overflow
);

   logic signed [COEFF_W-1:0] r_mem [2][BLK_N];

   logic                      r_wr_bank;
   logic                      r_rd_bank;
   logic [1:0]                r_full;
   logic                      r_overflow;
   rd_state_t                 r_state;
   logic [5:0]                r_rd_cnt;
   logic                      r_out_valid;
   logic signed [COEFF_W-1:0] r_out_coeff;
   logic [5:0]                r_out_index;
   logic                      r_blk_last;

   logic                      w_wr_try;
   logic                      w_wr_en;
   logic                      w_wr_drop;
   logic                      w_wr_close;
   logic                      w_load;
   logic                      w_emit;
   logic                      w_release;
   logic [5:0]                w_raster;
   logic [1:0]                w_full_nxt;
   rd_state_t                 w_state_nxt;
   logic [5:0]                w_rd_cnt_nxt;
   logic                      w_rd_bank_nxt;

   // ---------------- write side ----------------
   assign w_wr_try   = dctq_valid & ~hold;
   assign w_wr_en    = w_wr_try & ~r_full[r_wr_bank];
   assign w_wr_drop  = w_wr_try &  r_full[r_wr_bank];
   assign w_wr_close = w_wr_en & (addr == 6'd63);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_bank][addr] <= qcoeff;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_bank  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_close) begin
            r_wr_bank <= ~r_wr_bank;
         end
         if (w_wr_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // A bank can only be closed while empty and only released while full, so the
   // set and clear below never target the same bank on one edge.
   always_comb begin
      w_full_nxt = r_full;
      if (w_release) begin
         w_full_nxt[r_rd_bank] = 1'b0;
      end
      if (w_wr_close) begin
         w_full_nxt[r_wr_bank] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_full <= 2'b00;
      end else begin
         r_full <= w_full_nxt;
      end
   end

   // ---------------- read side ----------------
   dctq_zigzag_rom u_zz_rom (
      .i_zz_idx      (r_rd_cnt),
      .o_raster_addr (w_raster)
   );

   assign w_load    = ~r_out_valid | out_ready;
   assign w_emit    = (r_state == RD_STREAM) & w_load;
   assign w_release = w_emit & (r_rd_cnt == 6'd63);

   always_comb begin
      w_state_nxt   = r_state;
      w_rd_cnt_nxt  = r_rd_cnt;
      w_rd_bank_nxt = r_rd_bank;
      unique case (r_state)
         RD_IDLE: begin
            if (r_full[r_rd_bank]) begin
               w_state_nxt = RD_STREAM;
            end
         end
         RD_STREAM: begin
            if (w_emit) begin
               w_rd_cnt_nxt = r_rd_cnt + 6'd1;
               if (w_release) begin
                  w_rd_bank_nxt = ~r_rd_bank;
                  // Stay in STREAM when the next block is already waiting.
                  if (!r_full[~r_rd_bank]) begin
                     w_state_nxt = RD_IDLE;
                  end
               end
            end
         end
         default: w_state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= RD_IDLE;
         r_rd_cnt  <= 6'd0;
         r_rd_bank <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_cnt  <= w_rd_cnt_nxt;
         r_rd_bank <= w_rd_bank_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_coeff <= '0;
         r_out_index <= 6'd0;
         r_blk_last  <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= w_emit;
         if (w_emit) begin
            r_out_coeff <= r_mem[r_rd_bank][w_raster];
            r_out_index <= r_rd_cnt;
            r_blk_last  <= (r_rd_cnt == 6'd63);
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_coeff = r_out_coeff;
   assign out_index = r_out_index;
   assign blk_last  = r_blk_last;
   assign buf_full  = r_full[0] & r_full[1];
   assign overflow  = r_overflow;

endmodule
